dmem_access_ctrl: RTL

Load/store access controller and two-port arbiter in front of the data memory. Accepts requests from the core LSU (requester 0) and the debug/program loader (requester 1), grants one at a time, and drives the memory's address, write data, enable, read/write select and funct3 lines. Checks each request for an illegal width or an out-of-range address, and applies load sign or zero extension to read data. Sits between the core pipeline/loader and the data memory, which has a 1-cycle read latency.

---
 rtl/dmem_pkg.sv | 37 +++
 rtl/dmem_load_ext.sv | 25 ++
 rtl/dmem_access_ctrl.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the data-memory access controller.
//   - dmem_state_e : controller FSM state encoding
//   - F3_*         : RISC-V load/store funct3 width codes
//   - REQ_*        : requester indices (bit positions in req_valid/req_ready)
//   - f3_legal()   : width legality check for a load or a store
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } dmem_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int REQ_CORE = 0;
    localparam int REQ_DBG  = 1;

    // Stores only come in signed widths; loads additionally allow the
    // unsigned byte/half forms.
    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        logic ok;
        ok = 1'b0;
        case (f3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_BU, F3_HU:     ok = ~we;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/dmem_load_ext.sv
// dmem_load_ext: combinational load-data extender.
//   funct3_i [2:0]  load width/sign code
//   rdata_i  [31:0] raw memory read word
//   data_o   [31:0] sign- or zero-extended result (0 for non-load codes)
module dmem_load_ext
    import dmem_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] data_o
);

    always_comb begin
        data_o = '0;
        case (funct3_i)
            F3_B:    data_o = {{24{rdata_i[7]}}, rdata_i[7:0]};
            F3_BU:   data_o = {24'h0, rdata_i[7:0]};
            F3_H:    data_o = {{16{rdata_i[15]}}, rdata_i[15:0]};
            F3_HU:   data_o = {16'h0, rdata_i[15:0]};
            F3_W:    data_o = rdata_i;
            default: data_o = '0;
        endcase
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: two-port arbiter and load/store sequencer in front of a
// data memory with 1-cycle read latency.
//
// Requester 0 = core LSU, requester 1 = debug/program loader.
// Inputs : clk, rst_n (async active-low), req_valid[1:0], req_we[1:0],
//          req_funct3[5:0] ([3i+:3]), req_addr[63:0] ([32i+:32]),
//          req_wdata[63:0] ([32i+:32]), mem_rdata[31:0]
// Outputs: req_ready[1:0], rsp_valid[1:0], rsp_rdata[31:0], rsp_err,
//          mem_addr[31:0], mem_wdata[31:0], mem_en, mem_we, mem_funct3[2:0]
//
// Build option: define DMEM_ARB_RR_EN for round-robin arbitration between
// the two requesters; otherwise the core has fixed priority.
module dmem_access_ctrl
    import dmem_pkg::*;
#(
    parameter int ADDR_BITS = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [1:0]  req_we,
    input  logic [5:0]  req_funct3,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic [1:0]  rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [2:0]  mem_funct3,
    input  logic [31:0] mem_rdata
);

    dmem_state_e state_q, state_d;

    logic        gnt_q, gnt_d;          // 0 = core, 1 = debug
    logic        we_q, we_d;
    logic        err_q, err_d;
    logic [31:0] maddr_q, maddr_d;
    logic [31:0] mwdata_q, mwdata_d;
    logic [2:0]  mf3_q, mf3_d;
    logic [31:0] rdata_q, rdata_d;

    // ---------------------------------------------------------------
    // Arbitration
    // ---------------------------------------------------------------
    logic any_req;
    logic gnt_sel;

    assign any_req = |req_valid;

`ifdef DMEM_ARB_RR_EN
    // Last granted requester; reset value makes the core preferred.
    logic rr_last_q, rr_last_d;

    always_comb begin
        if (req_valid == 2'b11) gnt_sel = ~rr_last_q;
        else                    gnt_sel = ~req_valid[REQ_CORE];
    end

    always_comb begin
        rr_last_d = rr_last_q;
        if (state_q == IDLE && any_req) rr_last_d = gnt_sel;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rr_last_q <= 1'b1;
        else        rr_last_q <= rr_last_d;
    end
`else
    // Debug only wins when the core is not asking.
    always_comb begin
        gnt_sel = ~req_valid[REQ_CORE];
    end
`endif

    // ---------------------------------------------------------------
    // Selected request and legality
    // ---------------------------------------------------------------
    logic        sel_we;
    logic [2:0]  sel_f3;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        sel_addr_ok;
    logic        sel_legal;

    assign sel_we      = gnt_sel ? req_we[1]         : req_we[0];
    assign sel_f3      = gnt_sel ? req_funct3[5:3]   : req_funct3[2:0];
    assign sel_addr    = gnt_sel ? req_addr[63:32]   : req_addr[31:0];
    assign sel_wdata   = gnt_sel ? req_wdata[63:32]  : req_wdata[31:0];
    assign sel_addr_ok = ((sel_addr >> ADDR_BITS) == 32'h0);
    assign sel_legal   = sel_addr_ok && f3_legal(sel_we, sel_f3);

    // ---------------------------------------------------------------
    // Load extension
    // ---------------------------------------------------------------
    logic [31:0] ext_data;

    dmem_load_ext u_load_ext (
        .funct3_i (mf3_q),
        .rdata_i  (mem_rdata),
        .data_o   (ext_data)
    );

    // ---------------------------------------------------------------
    // FSM next state and datapath register updates
    // ---------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        we_d     = we_q;
        err_d    = err_q;
        maddr_d  = maddr_q;
        mwdata_d = mwdata_q;
        mf3_d    = mf3_q;
        rdata_d  = rdata_q;

        case (state_q)
            IDLE: begin
                if (any_req) begin
                    gnt_d = gnt_sel;
                    if (sel_legal) begin
                        // Memory-facing lines only move for legal
                        // requests so a rejected one leaves them intact.
                        we_d     = sel_we;
                        maddr_d  = sel_addr;
                        mwdata_d = sel_wdata;
                        mf3_d    = sel_f3;
                        err_d    = 1'b0;
                        state_d  = ACCESS;
                    end else begin
                        err_d   = 1'b1;
                        rdata_d = '0;
                        state_d = RESP;
                    end
                end
            end
            ACCESS: begin
                if (we_q) begin
                    rdata_d = '0;
                    state_d = RESP;
                end else begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                // Memory word is valid here, one cycle after ACCESS.
                rdata_d = ext_data;
                state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            gnt_q    <= 1'b0;
            we_q     <= 1'b0;
            err_q    <= 1'b0;
            maddr_q  <= '0;
            mwdata_q <= '0;
            mf3_q    <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            we_q     <= we_d;
            err_q    <= err_d;
            maddr_q  <= maddr_d;
            mwdata_q <= mwdata_d;
            mf3_q    <= mf3_d;
            rdata_q  <= rdata_d;
        end
    end

    // ---------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------
    // req_ready is combinational from IDLE; it is also masked by rst_n so
    // that nothing is offered to the requesters while reset is held.
    always_comb begin
        req_ready = 2'b00;
        if (rst_n && state_q == IDLE && any_req)
            req_ready = gnt_sel ? 2'b10 : 2'b01;
    end

    always_comb begin
        rsp_valid = 2'b00;
        if (state_q == RESP)
            rsp_valid = gnt_q ? 2'b10 : 2'b01;
    end

    assign rsp_err    = (state_q == RESP) && err_q;
    assign rsp_rdata  = rdata_q;
    assign mem_en     = (state_q == ACCESS);
    assign mem_we     = (state_q == ACCESS) && we_q;
    assign mem_addr   = maddr_q;
    assign mem_wdata  = mwdata_q;
    assign mem_funct3 = mf3_q;

endmodule
